// File: rtl/ifetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_queue
//
// Decoupled instruction-fetch front end. A sequential fetch PC (seeded from
// RESET_PC or a redirect target) is issued over a req/addr_ok/data_ok memory
// handshake with several requests allowed in flight. Every accepted request
// reserves a slot in an in-order queue of DEPTH entries; responses fill the
// slots in request order and decode drains the head through valid/ready.
// A redirect empties the queue and counts the still-outstanding responses so
// they can be dropped when they eventually return. A misaligned fetch PC
// never reaches memory; it becomes a single AdEL-tagged queue entry and fetch
// halts until the next redirect.
//
// Parameters
//   RESET_PC       first fetch address after reset
//   DEPTH          queue entries (power of two, 2..16); also caps the sum of
//                  in-flight requests and buffered instructions
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   redirect_valid flush and restart fetch at redirect_pc
//   redirect_pc    new fetch address
//   inst_req       fetch request valid
//   inst_addr      fetch address (fetch_pc while inst_req, else 0)
//   inst_addr_ok   memory accepts the request this cycle
//   inst_data_ok   one response, returned in request order
//   inst_rdata     response data
//   out_valid      head entry is filled
//   out_ready      decode accepts the head entry
//   out_pc         PC of the head entry
//   out_inst       instruction of the head entry (0 for exception entries)
//   out_ex         head entry carries a fetch exception
//   out_excode     5'h04 (AdEL) when out_ex, else 0
//   out_badvaddr   faulting PC when out_ex, else 0
// -----------------------------------------------------------------------------
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_ex,
  output logic [4:0]  out_excode,
  output logic [31:0] out_badvaddr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [4:0] EXC_ADEL = 5'h04;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [AW-1:0] idx_t;

  // Fetch control state
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        halted_q, halted_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  ptr_t alloc_ptr_q, alloc_ptr_d;
  ptr_t fill_ptr_q, fill_ptr_d;
  ptr_t read_ptr_q, read_ptr_d;
  ptr_t discard_cnt_q, discard_cnt_d;

  // Queue storage
  logic [31:0]      ent_pc_q   [DEPTH];
  logic [31:0]      ent_pc_d   [DEPTH];
  logic [31:0]      ent_inst_q [DEPTH];
  logic [31:0]      ent_inst_d [DEPTH];
  logic [DEPTH-1:0] ent_ex_q, ent_ex_d;
  logic [DEPTH-1:0] ent_filled_q, ent_filled_d;

  // Derived control
  ptr_t occupancy;
  ptr_t in_flight;
  idx_t alloc_idx;
  idx_t fill_idx;
  idx_t read_idx;
  logic has_room;
  logic pc_aligned;
  logic no_discard;
  logic accept;
  logic dequeue;
  logic mis_alloc;

  // Occupancy counts reserved slots, so in-flight requests already hold a
  // place in the queue and can never overflow it when they return.
  assign occupancy  = alloc_ptr_q - read_ptr_q;
  assign in_flight  = alloc_ptr_q - fill_ptr_q;
  assign alloc_idx  = alloc_ptr_q[AW-1:0];
  assign fill_idx   = fill_ptr_q[AW-1:0];
  assign read_idx   = read_ptr_q[AW-1:0];
  assign has_room   = occupancy < ptr_t'(DEPTH);
  assign pc_aligned = (fetch_pc_q[1:0] == 2'b00);
  assign no_discard = (discard_cnt_q == '0);

  // Fetch is held off while stale responses from before a redirect are still
  // returning, so a response can always be attributed to the current stream
  // by the discard count alone.
  assign inst_req  = !rst && !redirect_valid && !halted_q && pc_aligned &&
                     has_room && no_discard;
  assign inst_addr = inst_req ? fetch_pc_q : 32'h0;
  assign accept    = inst_req && inst_addr_ok;

  // The AdEL entry waits until everything ahead of it has returned so it
  // lands in program order behind the last real instruction.
  assign mis_alloc = !redirect_valid && !halted_q && !pc_aligned &&
                     (fill_ptr_q == alloc_ptr_q) && has_room && no_discard;

  // Head entry presentation; the filled bit is registered, so data_ok has
  // no combinational path to out_valid.
  assign out_valid    = (occupancy != '0) && ent_filled_q[read_idx];
  assign dequeue      = out_valid && out_ready;
  assign out_pc       = out_valid ? ent_pc_q[read_idx] : 32'h0;
  assign out_inst     = out_valid ? ent_inst_q[read_idx] : 32'h0;
  assign out_ex       = out_valid && ent_ex_q[read_idx];
  assign out_excode   = out_ex ? EXC_ADEL : 5'h00;
  assign out_badvaddr = out_ex ? ent_pc_q[read_idx] : 32'h0;

  // Next-state logic. A redirect overrides every other event in its cycle,
  // including a same-cycle dequeue, because decode flushes along with us.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    halted_d      = halted_q;
    alloc_ptr_d   = alloc_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    read_ptr_d    = read_ptr_q;
    discard_cnt_d = discard_cnt_q;
    ent_pc_d      = ent_pc_q;
    ent_inst_d    = ent_inst_q;
    ent_ex_d      = ent_ex_q;
    ent_filled_d  = ent_filled_q;

    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc;
      halted_d      = 1'b0;
      alloc_ptr_d   = '0;
      fill_ptr_d    = '0;
      read_ptr_d    = '0;
      ent_filled_d  = '0;
      // Every request still outstanding becomes stale; a response arriving
      // in this very cycle is one of them and is already consumed.
      discard_cnt_d = discard_cnt_q + in_flight - ptr_t'(inst_data_ok);
    end else begin
      if (inst_data_ok) begin
        if (!no_discard) begin
          discard_cnt_d = discard_cnt_q - ptr_t'(1);
        end else begin
          ent_inst_d[fill_idx]   = inst_rdata;
          ent_filled_d[fill_idx] = 1'b1;
          fill_ptr_d             = fill_ptr_q + ptr_t'(1);
        end
      end

      if (dequeue) begin
        ent_filled_d[read_idx] = 1'b0;
        read_ptr_d             = read_ptr_q + ptr_t'(1);
      end

      if (accept) begin
        ent_pc_d[alloc_idx]     = fetch_pc_q;
        ent_inst_d[alloc_idx]   = 32'h0;
        ent_ex_d[alloc_idx]     = 1'b0;
        ent_filled_d[alloc_idx] = 1'b0;
        alloc_ptr_d             = alloc_ptr_q + ptr_t'(1);
        fetch_pc_d              = fetch_pc_q + 32'd4;
      end

      // The exception entry is complete on allocation, so the fill pointer
      // moves with it; otherwise a later redirect would count it as an
      // outstanding response to discard.
      if (mis_alloc) begin
        ent_pc_d[alloc_idx]     = fetch_pc_q;
        ent_inst_d[alloc_idx]   = 32'h0;
        ent_ex_d[alloc_idx]     = 1'b1;
        ent_filled_d[alloc_idx] = 1'b1;
        alloc_ptr_d             = alloc_ptr_q + ptr_t'(1);
        fill_ptr_d              = fill_ptr_q + ptr_t'(1);
        halted_d                = 1'b1;
      end
    end
  end

  // Control state register. The memory side resets with us, so nothing is
  // left to discard after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      halted_q      <= 1'b0;
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      read_ptr_q    <= '0;
      discard_cnt_q <= '0;
      ent_filled_q  <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      halted_q      <= halted_d;
      alloc_ptr_q   <= alloc_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      read_ptr_q    <= read_ptr_d;
      discard_cnt_q <= discard_cnt_d;
      ent_filled_q  <= ent_filled_d;
    end
  end

  // Entry payload needs no reset: it is only ever observed behind a set
  // filled bit, which always follows a fresh write.
  always_ff @(posedge clk) begin
    ent_pc_q   <= ent_pc_d;
    ent_inst_q <= ent_inst_d;
    ent_ex_q   <= ent_ex_d;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// -----------------------------------------------------------------------------
// tb_ifetch_queue
//
// Drives ifetch_queue with a behavioural instruction memory (in-order,
// configurable latency) and compares every output on every cycle against a
// reference model that thinks in terms of fetch epochs: each redirect or
// reset starts a new epoch, responses tagged with an older epoch are stale,
// and the queue is simply the list of entries reserved in the current epoch.
// -----------------------------------------------------------------------------
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] MAGIC    = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ex;
  logic [4:0]  out_excode;
  logic [31:0] out_badvaddr;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_ex         (out_ex),
    .out_excode     (out_excode),
    .out_badvaddr   (out_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: the queue as seen by decode, and the memory's pending list
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          ex;
    bit          arrived;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  ent_t        mq[$];
  req_t        mem[$];
  logic [31:0] m_pc;
  bit          m_halted;
  int          epoch;
  int          cyc;
  int          lat_min;
  int          lat_max;
  bit          checks_on;

  int n_compared;
  int n_mismatched;

  // Observations recorded at handshakes, for the hand-computed checks
  logic [31:0] obs_addr[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_inst[$];
  logic [31:0] obs_ex[$];
  logic [31:0] obs_code[$];
  logic [31:0] obs_bad[$];

  function automatic int staleCount();
    int n = 0;
    foreach (mem[i]) if (mem[i].epoch != epoch) n++;
    return n;
  endfunction

  function automatic bit allArrived();
    foreach (mq[i]) if (!mq[i].arrived) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic clearObs();
    obs_addr.delete();
    obs_pc.delete();
    obs_inst.delete();
    obs_ex.delete();
    obs_code.delete();
    obs_bad.delete();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model across the rising edge.
  task automatic applyStimulus(input bit r, input bit rv, input logic [31:0] rpc,
                               input bit aok, input bit ordy);
    bit   e_req, e_valid, acc, deq, dok, mis;
    int   st, lat;
    ent_t e;
    req_t q;

    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_addr_ok   = aok;
    out_ready      = ordy;
    if (!r && mem.size() > 0 && mem[0].due <= cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem[0].addr ^ MAGIC;
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
    end
    #1;

    assert (!inst_data_ok || mem.size() > 0);

    st      = staleCount();
    e_req   = !r && !rv && !m_halted && (m_pc[1:0] == 2'b00) &&
              (mq.size() < DEPTH) && (st == 0);
    e_valid = (mq.size() > 0) && mq[0].arrived;

    if (checks_on) begin
      checkOutput("inst_req", 32'(inst_req), 32'(e_req));
      checkOutput("inst_addr", inst_addr, e_req ? m_pc : 32'h0);
      checkOutput("out_valid", 32'(out_valid), 32'(e_valid));
      if (e_valid) begin
        checkOutput("out_pc", out_pc, mq[0].pc);
        checkOutput("out_inst", out_inst, mq[0].inst);
        checkOutput("out_ex", 32'(out_ex), 32'(mq[0].ex));
        checkOutput("out_excode", 32'(out_excode), mq[0].ex ? 32'h4 : 32'h0);
        checkOutput("out_badvaddr", out_badvaddr, mq[0].ex ? mq[0].pc : 32'h0);
      end
    end

    acc = e_req && aok;
    deq = e_valid && ordy && !rv && !r;
    dok = inst_data_ok;
    mis = !m_halted && (m_pc[1:0] != 2'b00) && (st == 0) &&
          (mq.size() < DEPTH) && allArrived();

    if (acc) obs_addr.push_back(inst_addr);
    if (deq) begin
      obs_pc.push_back(out_pc);
      obs_inst.push_back(out_inst);
      obs_ex.push_back(32'(out_ex));
      obs_code.push_back(32'(out_excode));
      obs_bad.push_back(out_badvaddr);
    end

    @(posedge clk);

    if (r) begin
      mq.delete();
      mem.delete();
      m_pc     = RESET_PC;
      m_halted = 1'b0;
      epoch++;
      checks_on = 1'b1;
    end else if (rv) begin
      if (dok) void'(mem.pop_front());
      mq.delete();
      m_pc     = rpc;
      m_halted = 1'b0;
      epoch++;
    end else begin
      if (dok) begin
        q = mem.pop_front();
        if (q.epoch == epoch) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].arrived) begin
              e = mq[i];
              e.arrived = 1'b1;
              mq[i] = e;
              break;
            end
          end
        end
      end
      if (deq) void'(mq.pop_front());
      if (acc) begin
        lat = $urandom_range(lat_max, lat_min);
        mq.push_back('{pc: m_pc, inst: m_pc ^ MAGIC, ex: 1'b0, arrived: 1'b0});
        mem.push_back('{addr: m_pc, epoch: epoch, due: cyc + lat});
        m_pc = m_pc + 32'd4;
      end
      if (mis) begin
        mq.push_back('{pc: m_pc, inst: 32'h0, ex: 1'b1, arrived: 1'b1});
        m_halted = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic runStream(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] rpc;
    bit          r, rv;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    inst_rdata     = 32'h0;
    out_ready      = 1'b0;
    m_pc           = RESET_PC;
    m_halted       = 1'b0;
    epoch          = 0;
    cyc            = 0;
    lat_min        = 1;
    lat_max        = 1;
    checks_on      = 1'b0;
    n_compared     = 0;
    n_mismatched   = 0;

    // Reset state, sampled just after the reset edge with rst still high
    doReset();
    #1;
    checkOutput("reset inst_req", 32'(inst_req), 32'h0);
    checkOutput("reset inst_addr", inst_addr, 32'h0);
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset out_pc", out_pc, 32'h0);
    checkOutput("reset out_inst", out_inst, 32'h0);
    checkOutput("reset out_ex", 32'(out_ex), 32'h0);
    checkOutput("reset out_excode", 32'(out_excode), 32'h0);
    checkOutput("reset out_badvaddr", out_badvaddr, 32'h0);

    // Streaming from the reset vector with single-cycle memory
    clearObs();
    runStream(12);
    checkOutput("stream addr0", pick(obs_addr, 0), 32'hBFC00000);
    checkOutput("stream addr1", pick(obs_addr, 1), 32'hBFC00004);
    checkOutput("stream pc0", pick(obs_pc, 0), 32'hBFC00000);
    checkOutput("stream inst0", pick(obs_inst, 0), 32'h1A65A5A5);
    checkOutput("stream pc1", pick(obs_pc, 1), 32'hBFC00004);
    checkOutput("stream ex0", pick(obs_ex, 0), 32'h0);

    // Backpressure: decode stalled fills the queue after exactly DEPTH accepts
    doReset();
    clearObs();
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp accept count", 32'(obs_addr.size()), 32'd4);
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("bp drain pc0", pick(obs_pc, 0), 32'hBFC00000);
    checkOutput("bp drain pc3", pick(obs_pc, 3), 32'hBFC0000C);
    checkOutput("bp resume addr", pick(obs_addr, 4), 32'hBFC00010);

    // Redirect with three responses in flight (latency 3)
    doReset();
    lat_min = 3;
    lat_max = 3;
    runStream(8);
    clearObs();
    applyStimulus(1'b0, 1'b1, 32'h80001000, 1'b1, 1'b1);
    runStream(12);
    checkOutput("redir first addr", pick(obs_addr, 0), 32'h80001000);
    checkOutput("redir first pc", pick(obs_pc, 0), 32'h80001000);
    checkOutput("redir second pc", pick(obs_pc, 1), 32'h80001004);

    // Redirect coinciding with data_ok and a dequeue handshake
    doReset();
    lat_min = 1;
    lat_max = 1;
    runStream(8);
    clearObs();
    applyStimulus(1'b0, 1'b1, 32'h80003000, 1'b1, 1'b1);
    runStream(8);
    checkOutput("coinc first pc", pick(obs_pc, 0), 32'h80003000);
    checkOutput("coinc first inst", pick(obs_inst, 0), 32'h80003000 ^ MAGIC);

    // Misaligned redirect, then a resume
    clearObs();
    applyStimulus(1'b0, 1'b1, 32'h80001002, 1'b1, 1'b1);
    runStream(10);
    checkOutput("misal no request", 32'(obs_addr.size()), 32'd0);
    checkOutput("misal entry count", 32'(obs_pc.size()), 32'd1);
    checkOutput("misal out_ex", pick(obs_ex, 0), 32'h1);
    checkOutput("misal excode", pick(obs_code, 0), 32'h4);
    checkOutput("misal badvaddr", pick(obs_bad, 0), 32'h80001002);
    checkOutput("misal inst", pick(obs_inst, 0), 32'h0);
    clearObs();
    applyStimulus(1'b0, 1'b1, 32'h80002000, 1'b1, 1'b1);
    runStream(6);
    checkOutput("resume addr", pick(obs_addr, 0), 32'h80002000);
    checkOutput("resume pc", pick(obs_pc, 0), 32'h80002000);

    // Randomised traffic: handshakes, latency, redirects and occasional reset
    lat_min = 1;
    lat_max = 5;
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(2999, 0) == 0);
      rv = !r && ($urandom_range(99, 0) < 3);
      rnd = $urandom;
      case ($urandom_range(9, 0))
        0:       rpc = {rnd[31:2], 2'b01 + {1'b0, rnd[0]}};
        1:       rpc = 32'hFFFFFFF0;
        default: rpc = {rnd[31:2], 2'b00};
      endcase
      applyStimulus(r, rv, rpc, $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 70);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
